// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder memory.
// Holds the FSM state type, frame layout constants, opcode values and the
// default memory depth.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRxOp,
        StRxAddr,
        StRxData,
        StMemWr,
        StMemRd,
        StTxData
    } spi_mem_state_t;

    localparam int unsigned OP_BITS      = 1;
    localparam int unsigned ADDR_BITS    = 8;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned WR_FRAME_LEN = OP_BITS + ADDR_BITS + DATA_BITS;
    localparam int unsigned RD_FRAME_LEN = OP_BITS + ADDR_BITS;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    localparam int unsigned MEM_DEPTH = 32;

endpackage

// File: rtl/spi_mem_array.sv
// DEPTH x DW register array with synchronous active-low clear, one write port
// and one combinational read port.
// Ports:
//   clk   - clock
//   rst   - synchronous active-low clear of every word
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational)
module spi_mem_array #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_mem.sv
// SPI responder in front of a small register-array memory.
// Receives LSB-first frames on mosi: write = {data, addr, wr=1}, read = {addr, wr=0}.
// Writes finish with a one-cycle op_done pulse; reads pulse ready and then shift
// the stored byte out LSB-first on miso.
// Ports:
//   clk     - clock, all logic on rising edge
//   rst     - synchronous active-low reset
//   cs      - chip select, active low
//   mosi    - serial frame in
//   miso    - serial read data out
//   ready   - one-cycle pulse, read data about to be shifted out
//   op_done - one-cycle pulse, write committed
module spi_mem
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned AW    = ADDR_BITS,
    parameter int unsigned DW    = DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic ready,
    output logic op_done
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned AIW = $clog2(AW);
    localparam int unsigned DIW = $clog2(DW);
    localparam int unsigned CW  = 4;

    spi_mem_state_t state;
    logic [CW-1:0]  cnt;
    logic           wr_bit;
    logic [AW-1:0]  addr_sr;
    logic [DW-1:0]  data_sr;
    logic [DW-1:0]  tx_sr;

    logic [AW-1:0]  addr_next;
    logic           rd_in_range;
    logic [DW-1:0]  rd_data;
    logic [DW-1:0]  rd_byte;
    logic           mem_we;

    // The read port looks at the address including the bit being captured this
    // edge, so the byte and its bit0 can be registered together with ready.
    always_comb begin
        addr_next = addr_sr;
        addr_next[cnt[AIW-1:0]] = mosi;
    end

    assign rd_in_range = 32'(addr_next) < DEPTH;
    assign rd_byte     = rd_in_range ? rd_data : '0;
    assign mem_we      = (state == StMemWr) && (32'(addr_sr) < DEPTH);

    spi_mem_array #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(addr_sr[IW-1:0]),
        .wdata(data_sr),
        .raddr(addr_next[IW-1:0]),
        .rdata(rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            wr_bit  <= 1'b0;
            addr_sr <= '0;
            data_sr <= '0;
            tx_sr   <= '0;
            miso    <= 1'b0;
            ready   <= 1'b0;
            op_done <= 1'b0;
        end else begin
            ready   <= 1'b0;
            op_done <= 1'b0;
            case (state)
                StIdle: begin
                    miso <= 1'b0;
                    if (!cs) state <= StRxOp;
                end
                StRxOp: begin
                    if (cs) begin
                        state <= StIdle;
                    end else begin
                        wr_bit <= mosi;
                        cnt    <= '0;
                        state  <= StRxAddr;
                    end
                end
                StRxAddr: begin
                    if (cs) begin
                        state <= StIdle;
                    end else begin
                        addr_sr <= addr_next;
                        if (cnt == CW'(AW - 1)) begin
                            cnt <= '0;
                            if (wr_bit == OP_WR) begin
                                state <= StRxData;
                            end else begin
                                tx_sr <= rd_byte;
                                miso  <= rd_byte[0];
                                ready <= 1'b1;
                                state <= StMemRd;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StRxData: begin
                    if (cs) begin
                        state <= StIdle;
                    end else begin
                        data_sr[cnt[DIW-1:0]] <= mosi;
                        if (cnt == CW'(DW - 1)) begin
                            cnt     <= '0;
                            op_done <= 1'b1;
                            state   <= StMemWr;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StMemWr: begin
                    state <= StIdle;
                end
                StMemRd: begin
                    // bit0 is held for a second cycle so the initiator sees it at end of T1
                    miso  <= tx_sr[0];
                    cnt   <= CW'(1);
                    state <= StTxData;
                end
                StTxData: begin
                    if (cnt == CW'(DW)) begin
                        miso  <= 1'b0;
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        miso <= tx_sr[cnt[DIW-1:0]];
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
